xalu: RTL and testbench
=======================

XALU -- requirements
Module: xalu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: issue strobe for the operation on op, one cycle wide.
REQ-004 SHALL have port op, input, 3 bits: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op.
REQ-005 SHALL have port src_a, input, 32 bits: rs operand (dividend / multiplicand / mthi-mtlo data).
REQ-006 SHALL have port src_b, input, 32 bits: rt operand (divisor / multiplier).
REQ-007 SHALL have port flush, input, 1 bit: exception flush from the exception unit.
REQ-008 SHALL have port busy, output, 1 bit: operation in flight; this drives the stall unit's XALU_Busy input.
REQ-009 SHALL have ports hi and lo, each output, 32 bits: architectural HI/LO registers, driven directly from flops.

Function
REQ-010 SHALL accept start only when busy=0 and flush=0; start in any other cycle is ignored with no state change.
REQ-011 SHALL write mthi/mtlo data into hi/lo at the accepting edge; the value is visible in the next cycle; busy stays 0.
REQ-012 SHALL use FSM states IDLE, MUL, DIV; from IDLE, accepted mult/multu go to MUL and div/divu go to DIV; after the last iteration the FSM returns to IDLE.
REQ-013 SHALL hold busy=1 exactly while the FSM is in MUL or DIV, starting in the cycle after acceptance.
REQ-014 SHALL compute mult/multu as a 64-bit product, signed or unsigned, with {hi,lo} = product.
REQ-015 SHALL, for div/divu, set lo = quotient and hi = remainder; signed division truncates toward zero, and the remainder takes the dividend's sign.
REQ-016 SHALL implement division as a radix-2 iterative algorithm on operand magnitudes with sign fix-up at completion; busy is high for exactly 32 cycles.
REQ-017 SHALL handle division by zero as follows: lo=0xFFFFFFFF, hi=src_a, with normal 32-cycle latency.
REQ-018 SHALL handle signed 0x80000000 / 0xFFFFFFFF as follows: lo=0x80000000, hi=0.
REQ-019 SHALL leave hi/lo unchanged while busy=1 and update both at the final busy edge; results are visible in the first cycle with busy=0.
REQ-020 SHALL latch operands at acceptance, so src_a/src_b changes during busy have no effect.
REQ-021 SHALL NOT abort an in-flight operation on flush; the operation runs to completion because HI/LO are architectural once issued.

Reset
REQ-022 SHALL, while reset=1, force FSM=IDLE, busy=0, hi=0, lo=0, and clear the iteration counter.
REQ-023 SHALL, on reset asserted mid-operation, abandon the operation: no hi/lo update, and busy=0 the next cycle.
REQ-024 SHALL give reset priority over start and flush in the same cycle.

Configuration
REQ-025 SHALL support macro XALU_FAST_MULT_EN; when defined, mult/multu complete in one cycle: {hi,lo} is written at the accepting edge and busy stays 0.
REQ-026 SHALL, without XALU_FAST_MULT_EN, run mult/multu through state MUL with busy=1 for exactly 4 cycles; the product is computed in a registered multi-stage path.
REQ-027 SHALL NOT let XALU_FAST_MULT_EN affect divide, mthi/mtlo, reset or flush behaviour.

Verification
REQ-028 SHALL cover: mult src_a=0xFFFFFFFE, src_b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy 4 cycles (or 0 with macro).
REQ-029 SHALL cover: multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 SHALL cover: div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; busy exactly 32 cycles; a second start while busy is ignored.
REQ-031 SHALL cover: divu 100 / 0 -> lo=0xFFFFFFFF, hi=100; div 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-032 SHALL cover: mtlo 0x1234 with flush=1 -> lo unchanged; mthi 0xABCD with flush=0 -> hi=0xABCD next cycle, busy=0.
REQ-033 SHALL cover: reset asserted at cycle 10 of a divu -> busy=0, hi=lo=0 next cycle; a new divu 9/4 then yields lo=2, hi=1.

Source files
------------

// File: rtl/xalu.sv
// Multiply/divide unit owning the architectural HI/LO registers (mult, multu, div, divu, mthi, mtlo).
// Latency: mult/multu 4 busy cycles (0 with XALU_FAST_MULT_EN), div/divu 32 busy cycles, mthi/mtlo 0.
// Backpressure: start is accepted only while busy=0 and flush=0; otherwise it is dropped.
module xalu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef XALU_FAST_MULT_EN
    localparam bit FastMult = 1'b1;
`else
    localparam bit FastMult = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] quo;       // multiplicand magnitude for MUL, dividend/quotient shift register for DIV
    logic [31:0] mag_b;
    logic [31:0] rem;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] pp_ll, pp_lh, pp_hl, pp_hh;
    logic [63:0] prod;

    logic        accept;
    logic        op_mul, op_div, op_sgn;
    logic [31:0] mag_a_in, mag_b_in;
    logic [63:0] fast_prod;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [32:0] div_diff;
    logic [31:0] quo_nxt, rem_nxt;

    assign busy     = (state != IDLE);
    assign accept   = start && !busy && !flush;
    assign op_mul   = (op[2:1] == 2'b00);
    assign op_div   = (op[2:1] == 2'b01);
    assign op_sgn   = ~op[0];
    assign mag_a_in = (op_sgn && src_a[31]) ? -src_a : src_a;
    assign mag_b_in = (op_sgn && src_b[31]) ? -src_b : src_b;
    assign fast_prod = {{32{op_sgn & src_a[31]}}, src_a} * {{32{op_sgn & src_b[31]}}, src_b};

    // One restoring-division step on magnitudes; remainder always stays below the divisor.
    assign div_shift = {rem, quo[31]};
    assign div_ge    = (div_shift >= {1'b0, mag_b});
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign rem_nxt   = div_ge ? div_diff[31:0] : div_shift[31:0];
    assign quo_nxt   = {quo[30:0], div_ge};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op_div) begin
                        state_nxt = DIV;
                    end else if (op_mul && !FastMult) begin
                        state_nxt = MUL;
                    end
                end
            end
            MUL:     if (cnt == 5'd3)  state_nxt = IDLE;
            DIV:     if (cnt == 5'd31) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            quo   <= '0;
            mag_b <= '0;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            pp_ll <= '0;
            pp_lh <= '0;
            pp_hl <= '0;
            pp_hh <= '0;
            prod  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (op_mul || op_div) begin
                            quo   <= mag_a_in;
                            mag_b <= mag_b_in;
                            rem   <= '0;
                            neg_q <= op_sgn & (src_a[31] ^ src_b[31]);
                            neg_r <= op_sgn & src_a[31];
                        end
                        if (op_mul && FastMult) begin
                            {hi, lo} <= fast_prod;
                        end
                        if (op == 3'd4) hi <= src_a;
                        if (op == 3'd5) lo <= src_a;
                    end
                end
                MUL: begin
                    cnt <= cnt + 5'd1;
                    // Four-stage product: partial products, sum, sign fix-up, commit.
                    case (cnt[1:0])
                        2'd0: begin
                            pp_ll <= 32'(quo[15:0])  * 32'(mag_b[15:0]);
                            pp_lh <= 32'(quo[15:0])  * 32'(mag_b[31:16]);
                            pp_hl <= 32'(quo[31:16]) * 32'(mag_b[15:0]);
                            pp_hh <= 32'(quo[31:16]) * 32'(mag_b[31:16]);
                        end
                        2'd1: prod <= {pp_hh, pp_ll} + {16'b0, pp_lh, 16'b0} + {16'b0, pp_hl, 16'b0};
                        2'd2: if (neg_q) prod <= -prod;
                        default: {hi, lo} <= prod;
                    endcase
                end
                DIV: begin
                    cnt <= cnt + 5'd1;
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    if (cnt == 5'd31) begin
                        lo <= (mag_b == 32'd0) ? 32'hFFFF_FFFF : (neg_q ? -quo_nxt : quo_nxt);
                        hi <= neg_r ? -rem_nxt : rem_nxt;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_xalu.sv
// Scoreboarded bench for xalu: stimulus pushes expected HI/LO and busy length, a monitor compares.
module tb_xalu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIVS = 3'd2, DIVU = 3'd3, MTHI = 3'd4, MTLO = 3'd5;
`ifdef XALU_FAST_MULT_EN
    localparam int MulLen = 0;
`else
    localparam int MulLen = 4;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          len;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    int          n_checks = 0, n_pass = 0;

    xalu dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Reference model: plain 64-bit arithmetic on the operand values.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl, output int len);
        longint          sa, sb, sp, sq, sr;
        longint unsigned up;
        rh = m_hi; rl = m_lo; len = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MULT:  begin sp = sa * sb; {rh, rl} = sp; len = MulLen; end
            MULTU: begin up = longint'(a) * longint'(b); {rh, rl} = up; len = MulLen; end
            DIVS: begin
                len = 32;
                if (b == 0) begin rl = 32'hFFFF_FFFF; rh = a; end
                else begin sq = sa / sb; sr = sa % sb; rl = sq[31:0]; rh = sr[31:0]; end
            end
            DIVU: begin
                len = 32;
                if (b == 0) begin rl = 32'hFFFF_FFFF; rh = a; end
                else begin rl = a / b; rh = a % b; end
            end
            MTHI: rh = a;
            MTLO: rl = a;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic fl);
        exp_t e;
        start = 1'b1; op = o; src_a = a; src_b = b; flush = fl;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0; src_a = $urandom; src_b = $urandom;
        e.old_hi = m_hi; e.old_lo = m_lo;
        if (fl) begin
            e.hi = m_hi; e.lo = m_lo; e.len = 0;
        end else begin
            model(o, a, b, e.hi, e.lo, e.len);
        end
        m_hi = e.hi; m_lo = e.lo;
        q.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 100) begin
                check("timeout", 64'(q.size()), 64'd0);
                q.delete();
            end
        end
    endtask

    // Monitor: per queued op, count busy cycles, require HI/LO stable meanwhile, compare at completion.
    int cnt = 0;
    bit stable = 1'b1;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt = 0; stable = 1'b1;
            end else if (q.size() > 0) begin
                e = q[0];
                if (e.len == 0) begin
                    check("busy_idle", 64'(busy), 64'd0);
                    check("hi_imm", 64'(hi), 64'(e.hi));
                    check("lo_imm", 64'(lo), 64'(e.lo));
                    void'(q.pop_front());
                end else if (busy) begin
                    cnt++;
                    if (hi !== e.old_hi || lo !== e.old_lo) stable = 1'b0;
                end else begin
                    check("busy_len", 64'(cnt), 64'(e.len));
                    check("hilo_stable", 64'(stable), 64'd1);
                    check("hi", 64'(hi), 64'(e.hi));
                    check("lo", 64'(lo), 64'(e.lo));
                    void'(q.pop_front());
                    cnt = 0; stable = 1'b1;
                end
            end
        end
    end

    initial begin
        exp_t        r;
        logic [31:0] a, b;
        logic [2:0]  o;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        r.hi = '0; r.lo = '0; r.old_hi = '0; r.old_lo = '0; r.len = 0;
        q.push_back(r);
        wait_done();

        issue(MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_done();
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done();

        // Second start while busy must be dropped.
        issue(DIVS, 32'hFFFF_FFF9, 32'd2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; op = MTHI; src_a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        issue(DIVU, 32'd100, 32'd0, 1'b0);
        wait_done();
        issue(DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done();
        issue(DIVS, 32'hFFFF_FF9C, 32'd0, 1'b0);
        wait_done();

        issue(MTLO, 32'h1234, 32'd0, 1'b1);
        wait_done();
        issue(MTHI, 32'hABCD, 32'd0, 1'b0);
        wait_done();

        // Flush during an in-flight divide does not abort it.
        issue(DIVS, 32'd1000, 32'hFFFF_FFF9, 1'b0);
        flush = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b0;
        wait_done();

        // Reset in the middle of a divu abandons it.
        issue(DIVU, 32'd12345, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        r.hi = '0; r.lo = '0; r.old_hi = '0; r.old_lo = '0; r.len = 0;
        q.push_back(r);
        wait_done();
        issue(DIVU, 32'd9, 32'd4, 1'b0);
        wait_done();

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            issue(o, a, b, ($urandom_range(0, 7) == 0));
            wait_done();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
